// File: rtl/steer_pkg.sv
// Shared types, limits and the saturating clamp used throughout the steering controller.
package steer_pkg;

    typedef enum logic [1:0] {IDLE, RAMP, RUN} state_t;

    localparam int DATA_W   = 12;
    localparam int CMD_MAX  = 1023;
    localparam int CMD_MIN  = -1023;
    localparam int CORR_LIM = 2047;
    localparam int ERR_LIM  = 511;

    function automatic int sat_clamp(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/sat_integrator.sv
// 16-bit signed accumulator that saturates instead of wrapping; clr has priority over en.
module sat_integrator
    import steer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic signed [15:0] din,
    output logic signed [15:0] acc
);

    logic signed [15:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = 16'(sat_clamp(int'(acc_q) + int'(din), -32768, 32767));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/steer_pi_cntrl.sv
// Start/stop FSM with forward-speed ramp feeding a 2-stage saturating PI steering pipeline.
module steer_pi_cntrl
    import steer_pkg::*;
#(
    parameter logic [3:0]  KP        = 4'd3,
    parameter int          KI_SHIFT  = 4,
    parameter logic [10:0] RAMP_STEP = 11'd32,
    parameter logic [10:0] FWD_MAX   = 11'd640
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     go,
    input  logic signed [DATA_W-1:0] err,
    input  logic                     err_vld,
    output logic signed [10:0]       lft,
    output logic signed [10:0]       rht,
    output logic                     cmd_vld,
    output logic                     moving
);

    state_t             state_q, state_d;
    logic        [10:0] fwd_q, fwd_d;
    logic               moving_q, moving_d;
    logic               vld_p1_q, vld_p1_d;
    logic signed [14:0] prod_p1_q, prod_p1_d;
    logic signed [10:0] lft_q, lft_d, rht_q, rht_d;
    logic               cmd_vld_q, cmd_vld_d;

    logic               stop, accept;
    logic signed [9:0]  err_sat;
    logic signed [15:0] integ;
    int                 ramp_sum, corr, lft_sum, rht_sum;

    // A falling go overrides any coincident sample.
    always_comb begin
        stop     = (state_q != IDLE) && !go;
        accept   = err_vld && go && (state_q != IDLE);
        err_sat  = 10'(sat_clamp(int'(err), -(ERR_LIM + 1), ERR_LIM));
        ramp_sum = sat_clamp(int'(fwd_q) + int'(RAMP_STEP), 0, int'(FWD_MAX));
        state_d  = state_q;
        fwd_d    = fwd_q;
        case (state_q)
            IDLE: if (go) state_d = RAMP;
            RAMP: if (accept) begin
                fwd_d = 11'(ramp_sum);
                if (ramp_sum == int'(FWD_MAX)) state_d = RUN;
            end
            RUN:     fwd_d = FWD_MAX;
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            fwd_d   = '0;
        end
        moving_d = (state_d != IDLE);
    end

    // ---- stage 1: clip and scale the error, update the integrator ----
    always_comb begin
        vld_p1_d  = accept;
        prod_p1_d = accept ? 15'(int'(err_sat) * int'(KP)) : prod_p1_q;
    end

    sat_integrator u_integ (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stop),
        .en    (accept && (state_q == RUN)),
        .din   (16'(err_sat)),
        .acc   (integ)
    );

    // ---- stage 2: combine P and I, mix with forward speed, clamp ----
    always_comb begin
        corr      = sat_clamp(int'(prod_p1_q) + (int'(integ) >>> KI_SHIFT), -CORR_LIM, CORR_LIM);
        lft_sum   = sat_clamp(int'(fwd_q) + corr, CMD_MIN, CMD_MAX);
        rht_sum   = sat_clamp(int'(fwd_q) - corr, CMD_MIN, CMD_MAX);
        lft_d     = lft_q;
        rht_d     = rht_q;
        cmd_vld_d = vld_p1_q && !stop;
        if (stop) begin
            lft_d = '0;
            rht_d = '0;
        end else if (vld_p1_q) begin
            lft_d = 11'(lft_sum);
            rht_d = 11'(rht_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fwd_q     <= '0;
            moving_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            lft_q     <= '0;
            rht_q     <= '0;
            cmd_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fwd_q     <= fwd_d;
            moving_q  <= moving_d;
            vld_p1_q  <= vld_p1_d;
            lft_q     <= lft_d;
            rht_q     <= rht_d;
            cmd_vld_q <= cmd_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
    end

    assign lft     = lft_q;
    assign rht     = rht_q;
    assign cmd_vld = cmd_vld_q;
    assign moving  = moving_q;

endmodule

// File: tb/tb_steer_pi_cntrl.sv
// Directed bench for steer_pi_cntrl with hand-computed wheel commands.
module tb_steer_pi_cntrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               go;
    logic signed [11:0] err;
    logic               err_vld;
    logic signed [10:0] lft, rht;
    logic               cmd_vld, moving;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    steer_pi_cntrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .err     (err),
        .err_vld (err_vld),
        .lft     (lft),
        .rht     (rht),
        .cmd_vld (cmd_vld),
        .moving  (moving)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int e);
        err     = 12'(e);
        err_vld = 1'b1;
        tick();
        err_vld = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int el, input int er);
        chk({tag, "_vld"}, int'(cmd_vld), 1);
        chk({tag, "_lft"}, int'(lft), el);
        chk({tag, "_rht"}, int'(rht), er);
    endtask

    task automatic sample_chk(input string tag, input int e, input int el, input int er);
        strobe(e);
        chk({tag, "_n1"}, int'(cmd_vld), 0);
        tick();
        chk_out(tag, el, er);
    endtask

    // The motor controller must never see the -1024 code.
    always @(negedge clk) begin
        if (rst_n && cmd_vld)
            chk("no_h400", int'((lft == 11'h400) || (rht == 11'h400)), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go = 1'b0; err = '0; err_vld = 1'b0;
        tick(); tick();
        chk("rst_lft", int'(lft), 0);
        chk("rst_rht", int'(rht), 0);
        chk("rst_vld", int'(cmd_vld), 0);
        chk("rst_mov", int'(moving), 0);
        rst_n = 1'b1;
        tick();

        // samples in IDLE are ignored
        strobe(100);
        tick();
        chk("idle_vld", int'(cmd_vld), 0);
        chk("idle_lft", int'(lft), 0);

        go = 1'b1;
        tick();
        chk("go_mov", int'(moving), 1);

        // ramp to cruise speed with zero error
        for (int k = 1; k <= 20; k++) begin
            sample_chk($sformatf("ramp%0d", k), 0, 32 * k, 32 * k);
            tick();
            chk("ramp_pulse", int'(cmd_vld), 0);
            tick();
        end
        chk("run_mov", int'(moving), 1);

        // RUN: P = 300, I = 100 >>> 4 = 6
        sample_chk("run100", 100, 946, 334);
        tick();

        // back-to-back samples, integrator 110 -> 100 -> 100
        err = 12'sd10; err_vld = 1'b1;
        tick();
        err = -12'sd10;
        tick();
        chk_out("b2b_0", 676, 604);
        err = 12'sd0;
        tick();
        chk_out("b2b_1", 616, 664);
        err_vld = 1'b0;
        tick();
        chk_out("b2b_2", 646, 634);
        tick();
        chk("b2b_end", int'(cmd_vld), 0);

        // drive the integrator into positive saturation
        err = 12'sd2047; err_vld = 1'b1;
        for (int k = 0; k < 70; k++) tick();
        err_vld = 1'b0;
        tick(); tick();
        chk("sat_lft", int'(lft), 1023);
        chk("sat_rht", int'(rht), -1023);
        // integrator 32767-512 = 32255 -> 2015; P = -1536; corr = 479
        sample_chk("neg_clip", -2048, 1023, 161);
        tick();

        // stop with one sample in flight and another coincident with go falling
        err = 12'sd50; err_vld = 1'b1;
        tick();
        go = 1'b0; err = 12'sd60;
        tick();
        err_vld = 1'b0;
        chk("stop_vld", int'(cmd_vld), 0);
        chk("stop_lft", int'(lft), 0);
        chk("stop_rht", int'(rht), 0);
        chk("stop_mov", int'(moving), 0);
        tick();
        chk("stop_vld2", int'(cmd_vld), 0);
        tick();
        chk("stop_vld3", int'(cmd_vld), 0);

        // restart: integrator must have been cleared (corr = 0 in RAMP)
        go = 1'b1;
        tick();
        chk("re_mov", int'(moving), 1);
        sample_chk("re1", 0, 32, 32);
        sample_chk("re2", 0, 64, 64);
        sample_chk("re3", 0, 96, 96);

        // asynchronous reset mid-RAMP, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lft", int'(lft), 0);
        chk("arst_rht", int'(rht), 0);
        chk("arst_mov", int'(moving), 0);
        chk("arst_vld", int'(cmd_vld), 0);
        tick();
        rst_n = 1'b1;
        chk("arst_rel_mov", int'(moving), 0);
        tick();
        chk("arst_go_mov", int'(moving), 1);
        sample_chk("arst_ramp", 0, 32, 32);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
